// File: rtl/hash_arbiter_2to1.sv
// hash_arbiter_2to1: round-robin sharing of one sha256XMSS core
// between two requesters, each with a single pending flag.
module hash_arbiter_2to1 #(
  parameter int KEY_LEN = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_start,
  input  logic [1023:0]      req0_data_in,
  input  logic               req0_message_length,
  output logic               req0_done,
  output logic [KEY_LEN-1:0] req0_data_out,
  input  logic               req1_start,
  input  logic [1023:0]      req1_data_in,
  input  logic               req1_message_length,
  output logic               req1_done,
  output logic [KEY_LEN-1:0] req1_data_out,
  output logic               hash_start,
  output logic [1023:0]      hash_data_in,
  output logic               hash_message_length,
  input  logic               hash_done,
  input  logic [KEY_LEN-1:0] hash_data_out,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t             state_q;
  logic [1:0]         pend_q;
  logic [1:0]         pend_d;
  logic [1:0]         set_w;
  logic [1:0]         clr_w;
  logic               g_q;
  logic               g_d;
  logic               last_q;
  logic               done0_q;
  logic               done1_q;
  logic [KEY_LEN-1:0] dout0_q;
  logic [KEY_LEN-1:0] dout1_q;
  logic               fin_w;

  assign fin_w = (state_q == WAIT) && hash_done;
  assign set_w = {req1_start, req0_start};

  always_comb begin
    clr_w = 2'b00;
    if (fin_w) begin
      clr_w = g_q ? 2'b10 : 2'b01;
    end
  end

  // a start landing on the clearing edge keeps its flag
  assign pend_d = (pend_q & ~clr_w) | set_w;

  always_comb begin
    g_d = pend_q[1];
    if (pend_q == 2'b11) begin
      g_d = ~last_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 2'b00;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      pend_q  <= pend_d;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|pend_q) begin
            g_q     <= g_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT;
        end
        WAIT: begin
          if (hash_done) begin
            if (g_q) begin
              dout1_q <= hash_data_out;
              done1_q <= 1'b1;
            end else begin
              dout0_q <= hash_data_out;
              done0_q <= 1'b1;
            end
            last_q  <= g_q;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign hash_start = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);

  assign hash_data_in =
    g_q ? req1_data_in : req0_data_in;
  assign hash_message_length =
    g_q ? req1_message_length
        : req0_message_length;

  assign req0_done     = done0_q;
  assign req1_done     = done1_q;
  assign req0_data_out = dout0_q;
  assign req1_data_out = dout1_q;

endmodule

// File: tb/tb_hash_arbiter_2to1.sv
// tb_hash_arbiter_2to1: directed bench with a transaction-level
// arbiter model, a behavioural hash core and per-cycle compares.
module tb_hash_arbiter_2to1;
  localparam int KL  = 256;
  localparam int LAT = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           req0_start, req1_start;
  logic [1023:0]  req0_data_in, req1_data_in;
  logic           req0_message_length, req1_message_length;
  logic           req0_done, req1_done;
  logic [KL-1:0]  req0_data_out, req1_data_out;
  logic           hash_start;
  logic [1023:0]  hash_data_in;
  logic           hash_message_length;
  logic           hash_done;
  logic [KL-1:0]  hash_data_out;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int d0cnt = 0, d1cnt = 0, hscnt = 0;
  int hs_cyc = 0, start_cyc = 0;
  logic [1023:0] hs_data;
  int dlog[$];
  logic spur_idle = 1'b0, spur_issue = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hash_arbiter_2to1 #(.KEY_LEN(KL)) dut (
    .clk(clk), .reset(reset),
    .req0_start(req0_start), .req0_data_in(req0_data_in),
    .req0_message_length(req0_message_length),
    .req0_done(req0_done), .req0_data_out(req0_data_out),
    .req1_start(req1_start), .req1_data_in(req1_data_in),
    .req1_message_length(req1_message_length),
    .req1_done(req1_done), .req1_data_out(req1_data_out),
    .hash_start(hash_start), .hash_data_in(hash_data_in),
    .hash_message_length(hash_message_length),
    .hash_done(hash_done), .hash_data_out(hash_data_out),
    .busy(busy)
  );

  function automatic logic [KL-1:0] digest(
    input logic [1023:0] d, input logic l);
    return {d[127:0], ~d[127:0]} ^ {{(KL-1){1'b0}}, l};
  endfunction

  task automatic chk(input string nm,
                     input logic [1023:0] a,
                     input logic [1023:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s act(low256)=%h exp(low256)=%h",
               nm, a[255:0], e[255:0]);
    end
  endtask

  // Reference: a transaction is active, issued or not; one per edge.
  logic [1:0]    m_pend, m_done, m_clr;
  logic          m_act, m_iss, m_g, m_last;
  logic [KL-1:0] m_dout0, m_dout1;

  assign m_clr = (m_act && m_iss && hash_done)
               ? (m_g ? 2'b10 : 2'b01) : 2'b00;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pend <= 2'b00; m_done <= 2'b00;
      m_act <= 1'b0; m_iss <= 1'b0;
      m_g <= 1'b0; m_last <= 1'b1;
      m_dout0 <= '0; m_dout1 <= '0;
    end else begin
      m_done <= 2'b00;
      m_pend <= (m_pend & ~m_clr) | {req1_start, req0_start};
      if (!m_act) begin
        if (m_pend != 2'b00) begin
          m_act <= 1'b1;
          m_iss <= 1'b0;
          m_g <= (m_pend == 2'b11) ? !m_last : m_pend[1];
        end
      end else if (!m_iss) begin
        m_iss <= 1'b1;
      end else if (hash_done) begin
        m_act <= 1'b0;
        m_iss <= 1'b0;
        m_last <= m_g;
        if (m_g) begin
          m_done <= 2'b10; m_dout1 <= hash_data_out;
        end else begin
          m_done <= 2'b01; m_dout0 <= hash_data_out;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("busy", busy, m_act);
      chk("hash_start", hash_start, m_act && !m_iss);
      chk("req0_done", req0_done, m_done[0]);
      chk("req1_done", req1_done, m_done[1]);
      chk("req0_data_out", req0_data_out, m_dout0);
      chk("req1_data_out", req1_data_out, m_dout1);
      chk("hash_data_in", hash_data_in,
          m_g ? req1_data_in : req0_data_in);
      chk("hash_msg_len", hash_message_length,
          m_g ? req1_message_length : req0_message_length);
      if (req0_done) begin d0cnt++; dlog.push_back(0); end
      if (req1_done) begin d1cnt++; dlog.push_back(1); end
    end
  end

  // Behavioural core: digest appears LAT cycles after hash_start.
  initial begin
    int cnt;
    logic [KL-1:0] dig;
    cnt = 0; dig = '0;
    hash_done = 1'b0; hash_data_out = '0;
    forever begin
      @(negedge clk);
      hash_done = 1'b0;
      if (reset) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            hash_done = 1'b1;
            hash_data_out = dig;
          end
        end
        if (hash_start) begin
          hscnt++;
          hs_cyc = cyc;
          hs_data = hash_data_in;
          dig = digest(hash_data_in, hash_message_length);
          cnt = LAT;
          if (spur_issue) begin
            hash_done = 1'b1;
            hash_data_out = {8{32'hBAD0_BAD0}};
          end
        end
        if (spur_idle) begin
          hash_done = 1'b1;
          hash_data_out = {8{32'hDEAD_0001}};
          spur_idle = 1'b0;
        end
      end
    end
  end

  task automatic pulse(input logic s0, input logic s1);
    @(posedge clk); #1;
    req0_start = s0; req1_start = s1;
    @(posedge clk); #1;
    start_cyc = cyc;
    req0_start = 1'b0; req1_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (!busy && m_pend == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_core_done(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #2;
      if (hash_done && m_act && m_iss) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, ok, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk); #3; reset = 1'b1;
    @(negedge clk); #3; reset = 1'b0;
  endtask

  initial begin
    int b0, b1, bh;
    int exp_rr[4];
    logic ok;
    exp_rr = '{0, 1, 0, 1};
    reset = 1'b1;
    req0_start = 1'b0; req1_start = 1'b0;
    req0_data_in = '0; req1_data_in = '0;
    req0_message_length = 1'b0;
    req1_message_length = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hash_start", hash_start, 1'b0);
    chk("rst_dout0", req0_data_out, '0);
    chk("rst_dout1", req1_data_out, '0);
    @(posedge clk); #1; reset = 1'b0;

    // single request
    req0_data_in = 1024'h1;
    pulse(1'b1, 1'b0);
    wait_idle("t1_idle");
    chk("t1_hs_after_grant", hs_cyc - start_cyc, 1);
    chk("t1_hs_data", hs_data, 1024'h1);
    chk("t1_dout0", req0_data_out,
        256'h00000000000000000000000000000001_FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFE);
    chk("t1_d0cnt", d0cnt, 1);
    chk("t1_d1cnt", d1cnt, 0);
    chk("t1_hscnt", hscnt, 1);

    // tie straight from reset
    do_reset();
    req0_data_in = 1024'h1234;
    req1_data_in = 1024'h5;
    req1_message_length = 1'b1;
    b0 = d0cnt; b1 = d1cnt; bh = hscnt;
    dlog.delete();
    pulse(1'b1, 1'b1);
    wait_idle("t2_idle");
    chk("t2_ndone", dlog.size(), 2);
    if (dlog.size() == 2) begin
      chk("t2_first", dlog[0], 0);
      chk("t2_second", dlog[1], 1);
    end
    chk("t2_hs", hscnt - bh, 2);
    chk("t2_d0", d0cnt - b0, 1);
    chk("t2_d1", d1cnt - b1, 1);
    chk("t2_dout1", req1_data_out,
        256'h00000000000000000000000000000005_FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFB);

    // round robin after req1 was served
    do_reset();
    dlog.delete();
    pulse(1'b0, 1'b1);
    wait_idle("t3_idle_a");
    pulse(1'b1, 1'b1);
    wait_idle("t3_idle_b");
    pulse(1'b1, 1'b1);
    wait_idle("t3_idle_c");
    chk("t3_ndone", dlog.size(), 5);
    if (dlog.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("t3_rr%0d", i), dlog[i+1], exp_rr[i]);
      end
    end

    // restart on the done edge
    b1 = d1cnt; bh = hscnt;
    pulse(1'b0, 1'b1);
    wait_core_done("t4_core_done");
    req1_start = 1'b1;
    @(posedge clk); #1;
    req1_start = 1'b0;
    wait_idle("t4_idle");
    chk("t4_d1", d1cnt - b1, 2);
    chk("t4_hs", hscnt - bh, 2);

    // duplicate starts while pending or waiting
    do_reset();
    req0_data_in = 1024'hABCD;
    b0 = d0cnt; bh = hscnt;
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    wait_idle("t5_idle");
    chk("t5_d0", d0cnt - b0, 1);
    chk("t5_hs", hscnt - bh, 1);

    // stray hash_done in IDLE and in ISSUE
    b0 = d0cnt; b1 = d1cnt;
    spur_idle = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_idle_d0", d0cnt - b0, 0);
    chk("t6_idle_d1", d1cnt - b1, 0);
    spur_issue = 1'b1;
    req0_data_in = 1024'h77;
    pulse(1'b1, 1'b0);
    wait_idle("t6_idle");
    spur_issue = 1'b0;
    chk("t6_d0", d0cnt - b0, 1);
    chk("t6_dout0", req0_data_out, digest(1024'h77, 1'b0));

    // reset in the middle of WAIT
    req1_data_in = 1024'h9;
    pulse(1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (busy && m_iss) begin ok = 1'b1; break; end
    end
    chk("t7_in_wait", ok, 1'b1);
    b0 = d0cnt; b1 = d1cnt;
    #2; reset = 1'b1;
    #1;
    chk("t7_busy", busy, 1'b0);
    chk("t7_hash_start", hash_start, 1'b0);
    chk("t7_dout0", req0_data_out, '0);
    chk("t7_dout1", req1_data_out, '0);
    chk("t7_done0", req0_done, 1'b0);
    @(negedge clk); #3; reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("t7_no_d0", d0cnt - b0, 0);
    chk("t7_no_d1", d1cnt - b1, 0);
    req1_data_in = 1024'h42;
    pulse(1'b0, 1'b1);
    wait_idle("t7_idle");
    chk("t7_fresh_d1", d1cnt - b1, 1);
    chk("t7_fresh_dout1", req1_data_out,
        digest(1024'h42, 1'b1));

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
